stall_replay_queue: RTL and testbench
=====================================

# stall_replay_queue

Parametrised fetch-side replay buffer for the pipelined core.
- While decode asserts `stall`, it captures each valid fetched instruction in order.
- When the stall releases, it replays the captured instructions oldest-first, one per cycle, ahead of the live fetch stream.
- `use_q` tells the decode mux to take `out_instr` instead of the fetch output.
- It generalises the fixed 2-entry, 16-bit stall buffer to arbitrary width and depth, with full/empty status, an occupancy count and overflow detection.

## Interface
- `WIDTH`, default 16: instruction width in bits.
- `DEPTH`, default 4: entry count; power of two, at least 2.
- `CW`, default `$clog2(DEPTH+1)`: width of `count`. Derived; do not override.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: discard all queued entries (branch/redirect).
- `stall` in 1: decode stalled this cycle.
- `in_valid` in 1: `in_instr` holds a real fetched instruction.
- `in_instr` in WIDTH: instruction from fetch.
- `use_q` out 1: decode must take `out_instr`.
- `out_valid` out 1: `out_instr` holds a queued entry (count != 0).
- `out_instr` out WIDTH: oldest queued entry.
- `count` out CW: occupancy, 0..DEPTH.
- `full` out 1: count == DEPTH.
- `overflow` out 1: sticky; a push was dropped because the queue was full.

## Operation
Storage and pointers:
- Circular buffer `mem[0..DEPTH-1]`.
- Head and tail pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH naturally.
- `count` is held in a separate register; it is not derived from the pointers.

Per-edge priority:
1. **flush**: head = tail = count = 0; overflow = 0; no push, no pop; `mem` contents untouched.
2. **stall && in_valid && !full**: write `mem[tail]` = `in_instr`; tail += 1; count += 1.
3. **stall && in_valid && full**: no write; overflow = 1.
4. **!stall && count != 0**: pop; head += 1; count -= 1.
5. **Otherwise**: hold.

Push and pop are mutually exclusive because push requires `stall` and pop requires `!stall`, so there is no simultaneous-access case.

Combinational outputs:
- `use_q = stall | (count != 0)`.
- `out_valid = (count != 0)`.
- `out_instr = mem[head]`. This value is stale when count = 0; consumers gate it with `out_valid`.
- `full = (count == DEPTH)`.

Input and overflow rules:
- `in_valid` = 0 during a stall is not an error: nothing is pushed.
- `overflow` stays set until `flush` or reset.

## Timing
- Reset (asynchronous assertion, values take effect immediately):
  - head, tail, count = 0; overflow = 0; all `mem` entries = 0.
  - Hence `out_instr` = 0, `out_valid` = 0, `full` = 0, and `use_q` = `stall`.
- Deassertion of `rst_n` is synchronised externally; the block takes no action on it.
- Reset mid-replay or mid-stall discards everything.
- Push latency: an entry written at edge N is visible on `out_instr` from after edge N, provided it is the oldest entry.
- Replay: with `stall` falling before edge M and count = k, `out_instr` presents entries 1..k in the cycles ending at edges M..M+k-1. `use_q` drops in the cycle after edge M+k-1.
- Wrap-around at DEPTH: pointers roll from DEPTH-1 to 0 with no gap or bubble.
- If stall reasserts mid-replay, popping pauses and new pushes append behind the remaining entries, so order is preserved.
- Flush takes effect at the edge where it is sampled. In that same cycle `use_q` still reflects pre-flush state; from the next cycle `use_q` = `stall`.

## Configuration
- Macro: `STALL_REPLAY_OVF_EN`.
- Defined: the overflow register and sticky `overflow` output operate as described above.
- Undefined:
  - The overflow register is not built and `overflow` is tied to 0.
  - A push while full is still dropped silently; the queue state is identical to the defined case.

## Test plan
1. **Basic stall and replay**: reset, then stall for 2 cycles with `in_valid` = 1 and `in_instr` = 0x1111, 0x2222; release stall.
   - Expect count = 2.
   - Then `out_instr` = 0x1111 and 0x2222 on consecutive cycles, with `use_q` = 1, 1, then 0, and count = 2 → 1 → 0.
2. **Overflow**: with DEPTH = 4, stall 5 cycles with A, B, C, D, E.
   - Expect `full` = 1 after D and E dropped.
   - Expect `overflow` = 1 when the macro is defined, 0 when not.
   - Replay yields exactly A, B, C, D.
3. **Wrap-around**: push 3, replay 3, then push 3 (X, Y, Z), crossing index DEPTH-1 → 0.
   - Replay yields X, Y, Z in order; count returns to 0.
4. **Flush mid-replay**: load 3 entries, pop 1, assert `flush` with `stall` = 1 and `in_valid` = 1.
   - Expect count = 0, no push, `overflow` cleared, and `use_q` = `stall` the next cycle.
5. **Async reset mid-operation**: with count = 3 and `overflow` = 1, pulse `rst_n` low between clock edges.
   - Immediately count = 0, `overflow` = 0, `out_valid` = 0, `out_instr` = 0.
6. **Bubbles during stall**: stall 4 cycles with `in_valid` pattern 1, 0, 0, 1 (values 0xAAAA, 0xBBBB).
   - Expect count = 2; replay yields 0xAAAA then 0xBBBB.

Source files
------------

// File: rtl/stall_replay_queue.sv
// Fetch-side replay buffer: captures fetched instructions while decode stalls and
// replays them oldest-first afterwards. Optional sticky overflow flag: STALL_REPLAY_OVF_EN.
module stall_replay_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_instr,
    output logic             use_q,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_instr,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             overflow
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [CW-1:0]    count_reg;
    logic             nonempty;
    logic             push;
    logic             drop;
    logic             pop;

    assign nonempty = (count_reg != '0);
    assign full     = (count_reg == CW'(DEPTH));

    // Push needs stall and pop needs !stall, so they never coincide.
    assign push = !flush && stall && in_valid && !full;
    assign drop = !flush && stall && in_valid && full;
    assign pop  = !flush && !stall && nonempty;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (push && (tail_reg == PW'(gi))) begin
                    mem_reg[gi] <= in_instr;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (push) begin
            tail_reg  <= tail_reg + 1'b1;
            count_reg <= count_reg + 1'b1;
        end else if (pop) begin
            head_reg  <= head_reg + 1'b1;
            count_reg <= count_reg - 1'b1;
        end
    end

`ifdef STALL_REPLAY_OVF_EN
    logic overflow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (flush) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign overflow    = 1'b0;
`endif

    // out_instr is stale when empty; consumers qualify it with out_valid.
    assign use_q     = stall | nonempty;
    assign out_valid = nonempty;
    assign out_instr = mem_reg[head_reg];
    assign count     = count_reg;

endmodule

// File: tb/tb_stall_replay_queue.sv
// Self-checking bench for stall_replay_queue: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_stall_replay_queue;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef STALL_REPLAY_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             stall;
    logic             in_valid;
    logic [WIDTH-1:0] in_instr;
    logic             use_q;
    logic             out_valid;
    logic [WIDTH-1:0] out_instr;
    logic [CW-1:0]    count;
    logic             full;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] model_q [$];
    logic             model_ovf;

    stall_replay_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .stall    (stall),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .use_q    (use_q),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .count    (count),
        .full     (full),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the model (inputs already applied).
    task automatic check_all(input string tag);
        chk({tag, ":use_q"}, 32'(use_q), 32'(stall | (model_q.size() != 0)));
        chk({tag, ":out_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
        chk({tag, ":count"}, 32'(count), 32'(model_q.size()));
        chk({tag, ":full"}, 32'(full), 32'(model_q.size() == DEPTH));
        chk({tag, ":overflow"}, 32'(overflow), 32'(model_ovf));
        if (model_q.size() != 0)
            chk({tag, ":out_instr"}, 32'(out_instr), 32'(model_q[0]));
    endtask

    // One clock cycle: drive at negedge, check before posedge, update model at posedge.
    task automatic cycle(input string tag, input logic f, input logic s,
                         input logic v, input logic [WIDTH-1:0] d);
        flush    = f;
        stall    = s;
        in_valid = v;
        in_instr = d;
        #1;
        check_all(tag);
        $display("%-8s t=%0t flush=%0b stall=%0b vld=%0b in=%h | use_q=%0b ov=%0b out=%h cnt=%0d full=%0b ovf=%0b",
                 tag, $time, f, s, v, d, use_q, out_valid, out_instr, count, full, overflow);
        @(posedge clk);
        if (f) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else if (s && v) begin
            if (model_q.size() < DEPTH) model_q.push_back(d);
            else if (OVF_EN) model_ovf = 1'b1;
        end else if (!s && model_q.size() != 0) begin
            void'(model_q.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        model_ovf = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst:count", 32'(count), 32'd0);
        chk("rst:out_valid", 32'(out_valid), 32'd0);
        chk("rst:out_instr", 32'(out_instr), 32'd0);
        chk("rst:full", 32'(full), 32'd0);
        chk("rst:overflow", 32'(overflow), 32'd0);
        chk("rst:use_q", 32'(use_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: basic stall and replay
        cycle("t1", 0, 1, 1, 16'h1111);
        cycle("t1", 0, 1, 1, 16'h2222);
        cycle("t1", 0, 0, 0, 16'h0000);
        cycle("t1", 0, 0, 0, 16'h0000);
        cycle("t1", 0, 0, 0, 16'h0000);

        // 2: overflow with five pushes into four entries
        cycle("t2", 0, 1, 1, 16'h000A);
        cycle("t2", 0, 1, 1, 16'h000B);
        cycle("t2", 0, 1, 1, 16'h000C);
        cycle("t2", 0, 1, 1, 16'h000D);
        cycle("t2", 0, 1, 1, 16'h000E);
        repeat (5) cycle("t2", 0, 0, 0, 16'h0000);
        cycle("t2f", 1, 0, 0, 16'h0000);

        // 3: wrap-around
        cycle("t3", 0, 1, 1, 16'h0301);
        cycle("t3", 0, 1, 1, 16'h0302);
        cycle("t3", 0, 1, 1, 16'h0303);
        repeat (3) cycle("t3", 0, 0, 0, 16'h0000);
        cycle("t3", 0, 1, 1, 16'h5858);
        cycle("t3", 0, 1, 1, 16'h5959);
        cycle("t3", 0, 1, 1, 16'h5A5A);
        repeat (4) cycle("t3", 0, 0, 0, 16'h0000);

        // 4: flush mid-replay while stalled with a valid input
        cycle("t4", 0, 1, 1, 16'h4401);
        cycle("t4", 0, 1, 1, 16'h4402);
        cycle("t4", 0, 1, 1, 16'h4403);
        cycle("t4", 0, 0, 0, 16'h0000);
        cycle("t4", 1, 1, 1, 16'h4404);
        cycle("t4", 0, 0, 0, 16'h0000);
        cycle("t4", 0, 1, 0, 16'h0000);

        // 5: async reset mid-operation with count=3 and overflow possibly set
        repeat (5) cycle("t5", 0, 1, 1, 16'h5500);
        cycle("t5", 0, 0, 0, 16'h0000);
        check_all("t5pre");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5:count", 32'(count), 32'd0);
        chk("t5:overflow", 32'(overflow), 32'd0);
        chk("t5:out_valid", 32'(out_valid), 32'd0);
        chk("t5:out_instr", 32'(out_instr), 32'd0);
        chk("t5:use_q", 32'(use_q), 32'(stall));
        model_q.delete();
        model_ovf = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        // 6: bubbles during stall
        cycle("t6", 0, 1, 1, 16'hAAAA);
        cycle("t6", 0, 1, 0, 16'h1234);
        cycle("t6", 0, 1, 0, 16'h5678);
        cycle("t6", 0, 1, 1, 16'hBBBB);
        repeat (3) cycle("t6", 0, 0, 0, 16'h0000);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6),
                  1'($urandom), WIDTH'($urandom));
        end
        check_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
